// File: rtl/instr_fetch.sv
// Fetch stage of the RV32I core: owns the PC, issues one valid/ready fetch at a
// time, holds the instruction for the control unit and advances on retirement.
module instr_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        nrst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] instr_out,
   output logic        instr_valid,
   output logic [31:0] pc_out,
   input  logic [31:0] pc_next_in,
   input  logic        retire_in,
   output logic        misalign_err,
   output logic        timeout_err,
   output logic [31:0] instret_out
);

   typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   state_t      state, state_next;
   logic        req_valid_q;
   logic [15:0] cnt;
   logic        accept, load_rsp, commit, trap_misalign, trap_timeout, cnt_inc;

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = pc_out;

   always_ff @(posedge clk) begin
      if (!nrst) state <= REQ;
      else       state <= state_next;
   end

   always_comb begin
      state_next    = state;
      accept        = 1'b0;
      load_rsp      = 1'b0;
      commit        = 1'b0;
      trap_misalign = 1'b0;
      trap_timeout  = 1'b0;
      cnt_inc       = 1'b0;
      case (state)
         REQ: begin
            if (req_valid_q && imem_req_ready) begin
               accept     = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               load_rsp   = 1'b1;
               state_next = HOLD;
            end else if (cnt == TO_LAST) begin
               trap_timeout = 1'b1;
               state_next   = HALT;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         HOLD: begin
            if (retire_in) begin
               if (pc_next_in[1:0] == 2'b00) begin
                  commit     = 1'b1;
                  state_next = REQ;
               end else begin
                  trap_misalign = 1'b1;
                  state_next    = HALT;
               end
            end
         end
         default: state_next = HALT;
      endcase
   end

   // Request valid is registered so it stays low through reset and rises the
   // first cycle after release, and again the cycle after each retirement.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         req_valid_q  <= 1'b0;
         cnt          <= '0;
         pc_out       <= RESET_PC;
         instr_out    <= NOP_INSTR;
         instr_valid  <= 1'b0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
         instret_out  <= '0;
      end else begin
         req_valid_q <= (state_next == REQ);
         if (accept)       cnt <= '0;
         else if (cnt_inc) cnt <= cnt + 16'd1;
         if (load_rsp) begin
            instr_out   <= imem_rsp_data;
            instr_valid <= 1'b1;
         end
         if (commit) begin
            pc_out      <= pc_next_in;
            instret_out <= instret_out + 32'd1;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
         end
         if (trap_misalign) begin
            misalign_err <= 1'b1;
            instr_out    <= NOP_INSTR;
            instr_valid  <= 1'b0;
         end
         if (trap_timeout) timeout_err <= 1'b1;
      end
   end

endmodule
